// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : shared types for the write-back queue unit.  Rev 1.0
// ============================================================================
package wb_pkg;

  localparam int WB_DATA_W  = 32;
  localparam int WB_RADDR_W = 5;

  typedef enum logic [1:0] {
    SRC_ALU  = 2'd0,
    SRC_MEM  = 2'd1,
    SRC_LINK = 2'd2
  } wb_src_e;

  typedef enum logic [1:0] {
    LD_BYTE = 2'd0,
    LD_HALF = 2'd1,
    LD_WORD = 2'd2,
    LD_FULL = 2'd3
  } ld_size_e;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_entry_t;

endpackage
`default_nettype wire

// File: rtl/wb_load_format.sv
`default_nettype none
// ============================================================================
// wb_load_format : big-endian sub-word select, alignment check, extension.
// Rev 1.0
// ============================================================================
module wb_load_format
  import wb_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OFF_W  = $clog2(DATA_W / 8)
) (
  input  logic [DATA_W-1:0] mem_data,
  input  logic [OFF_W-1:0]  offset,
  input  ld_size_e          size,
  input  logic              ld_unsigned,
  output logic [DATA_W-1:0] data_out,
  output logic              misaligned
);

  localparam logic [DATA_W-1:0] c_one = 1;

  logic [DATA_W-1:0] w_shifted;
  logic [DATA_W-1:0] w_zext;
  logic [DATA_W-1:0] w_mask;
  logic              w_fill;
  int                w_nbits;

  // Left-justify the addressed byte so the loaded field's MSB sits at the top.
  always_comb begin
    w_shifted  = mem_data << {offset, 3'b000};
    w_nbits    = DATA_W;
    misaligned = 1'b0;
    case (size)
      LD_BYTE: w_nbits = 8;
      LD_HALF: begin
        w_nbits    = 16;
        misaligned = offset[0];
      end
      LD_WORD: begin
        w_nbits    = 32;
        misaligned = (offset[1:0] != 2'b00);
      end
      default: begin
        w_nbits    = DATA_W;
        misaligned = (offset != '0);
      end
    endcase
    w_zext   = w_shifted >> (DATA_W - w_nbits);
    w_mask   = (w_nbits >= DATA_W) ? '1 : ((c_one << w_nbits) - c_one);
    w_fill   = !ld_unsigned && w_shifted[DATA_W-1] && (w_nbits < DATA_W);
    data_out = w_fill ? (w_zext | ~w_mask) : w_zext;
  end

endmodule
`default_nettype wire

// File: rtl/wb_queue_unit.sv
`default_nettype none
// ============================================================================
// wb_queue_unit : write-back source select, load formatting, in-order queue
// to a stallable register-file port, with bypass lookup.  Rev 1.0
// ============================================================================
module wb_queue_unit
  import wb_pkg::*;
#(
  parameter int DATA_W      = WB_DATA_W,
  parameter int RADDR_W     = WB_RADDR_W,
  parameter int DEPTH       = 2,
  parameter int LINK_OFFSET = 8
) (
  input  logic                         clk,
  input  logic                         rst_b,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_reg_write,
  input  logic [RADDR_W-1:0]           in_rd,
  input  logic [1:0]                   in_src,
  input  logic [1:0]                   in_ld_size,
  input  logic                         in_ld_unsigned,
  input  logic [$clog2(DATA_W/8)-1:0]  in_mem_block,
  input  logic [DATA_W-1:0]            in_mem_data,
  input  logic [DATA_W-1:0]            in_alu_result,
  input  logic [DATA_W-1:0]            in_pc,
  input  logic                         rf_ready,
  output logic                         rf_we,
  output logic [RADDR_W-1:0]           rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [RADDR_W-1:0]           fwd_raddr,
  output logic                         fwd_hit,
  output logic [DATA_W-1:0]            fwd_data,
  output logic                         misalign_err,
  output logic [31:0]                  wb_count
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = c_ptr_w + 1;
  localparam logic [DATA_W-1:0]  c_link  = DATA_W'(LINK_OFFSET);
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef struct packed {
    logic [RADDR_W-1:0] rd;
    logic [DATA_W-1:0]  data;
  } entry_t;

  entry_t             r_q [DEPTH];
  logic [c_ptr_w-1:0] r_head;
  logic [c_ptr_w-1:0] r_tail;
  logic [c_cnt_w-1:0] r_count;
  logic               r_misalign;
  logic [31:0]        r_wb_count;

  logic [DATA_W-1:0]  w_load_data;
  logic               w_load_misaligned;
  logic [DATA_W-1:0]  w_fmt_data;
  logic               w_accept;
  logic               w_misalign;
  logic               w_push;
  logic               w_pop;
  logic [c_ptr_w-1:0] w_idx;

  wb_load_format #(
    .DATA_W (DATA_W)
  ) u_load_format (
    .mem_data    (in_mem_data),
    .offset      (in_mem_block),
    .size        (ld_size_e'(in_ld_size)),
    .ld_unsigned (in_ld_unsigned),
    .data_out    (w_load_data),
    .misaligned  (w_load_misaligned)
  );

  always_comb begin
    case (in_src)
      SRC_MEM:  w_fmt_data = w_load_data;
      SRC_LINK: w_fmt_data = in_pc + c_link;
      default:  w_fmt_data = in_alu_result;
    endcase
  end

  assign in_ready   = (r_count != c_depth);
  assign w_accept   = in_valid && in_ready;
  assign w_misalign = (in_src == SRC_MEM) && w_load_misaligned;
  assign w_push     = w_accept && in_reg_write && (in_rd != '0) && !w_misalign;
  assign w_pop      = rf_we && rf_ready;

  assign rf_we        = (r_count != '0);
  assign rf_waddr     = rf_we ? r_q[r_head].rd : '0;
  assign rf_wdata     = rf_we ? r_q[r_head].data : '0;
  assign misalign_err = r_misalign;
  assign wb_count     = r_wb_count;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_q[i] <= '0;
      end
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_misalign <= 1'b0;
      r_wb_count <= '0;
    end else begin
      r_misalign <= w_accept && w_misalign;
      if (w_push) begin
        r_q[r_tail] <= '{rd: in_rd, data: w_fmt_data};
        r_tail      <= r_tail + 1'b1;
      end
      if (w_pop) begin
        r_head     <= r_head + 1'b1;
        r_wb_count <= r_wb_count + 32'd1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    w_idx    = r_head;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + c_ptr_w'(i);
      if ((c_cnt_w'(i) < r_count) && (fwd_raddr != '0) &&
          (r_q[w_idx].rd == fwd_raddr)) begin
        fwd_hit  = 1'b1;
        fwd_data = r_q[w_idx].data;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/wb_queue_unit.md
# wb_queue_unit

Parametrised write-back unit between the MEM/WB pipeline register and the register-file write port. Selects the write-back source (ALU, memory, link), aligns and sign/zero-extends sub-word loads of any size, and holds results in a small in-order write-back queue. The queue decouples the pipeline from a register-file port that can stall, and it exposes a bypass lookup for younger instructions.

## Interface
Parameters:
- DATA_W, 32, datapath width; multiple of 32 (32 or 64).
- RADDR_W, 5, register index width.
- DEPTH, 2, queue entries; power of two, ≥2.
- LINK_OFFSET, 8, added to pc for link write-back.

Ports (reset rst_b, asynchronous, active-low; clock clk):
- clk  in  1  clock, rising edge.
- rst_b  in  1  asynchronous active-low reset.
- in_valid  in  1  MEM stage presents a result.
- in_ready  out  1  queue can accept; equals !full.
- in_reg_write  in  1  instruction writes a register.
- in_rd  in  RADDR_W  destination register.
- in_src  in  2  0=ALU, 1=MEM, 2=LINK, 3=reserved (treated as ALU).
- in_ld_size  in  2  0=byte, 1=half, 2=word(32), 3=full(DATA_W).
- in_ld_unsigned  in  1  zero-extend instead of sign-extend.
- in_mem_block  in  log2(DATA_W/8)  byte offset within in_mem_data.
- in_mem_data  in  DATA_W  cache read data, big-endian (byte 0 = MSB).
- in_alu_result  in  DATA_W  ALU result.
- in_pc  in  DATA_W  instruction PC.
- rf_ready  in  1  register-file port accepts a write this cycle.
- rf_we  out  1  write strobe (registered).
- rf_waddr  out  RADDR_W  write index.
- rf_wdata  out  DATA_W  write data.
- fwd_raddr  in  RADDR_W  bypass lookup index.
- fwd_hit  out  1  a queued entry targets fwd_raddr.
- fwd_data  out  DATA_W  data of the youngest matching entry.
- misalign_err  out  1  one-cycle pulse; the load was dropped.
- wb_count  out  32  retired register writes, wrapping.

## Operation
- Accept when in_valid && in_ready.
- Entries with in_reg_write=0 or in_rd=0 are accepted but not enqueued.
- Data formatting is combinational at the input, so formatted data is stored:
  - ALU: in_alu_result.
  - LINK: in_pc + LINK_OFFSET, modulo 2^DATA_W.
  - MEM byte: the byte at in_mem_block, extended.
  - MEM half: bytes off and off+1; off+1 is the LSB.
  - MEM word: 4 bytes from off.
  - MEM full: all of in_mem_data.
- Extension fills bits above the loaded size with its MSB, or with 0 if in_ld_unsigned. Full size has no extension.
- Alignment rules: half needs an even off; word needs off%4==0; full needs off==0.
  - On violation: the entry is not enqueued, and misalign_err=1 in the next cycle.
  - Non-MEM sources ignore the offset.
- Queue is in-order FIFO with head and tail pointers wrapping modulo DEPTH, plus an occupancy count.
- Output register: rf_we/rf_waddr/rf_wdata hold the head entry. rf_we=1 whenever the queue is non-empty.
  - The head pops on rf_we && rf_ready, and wb_count increments.
  - If rf_ready=0, the outputs hold stable.
- Bypass: combinational search over valid entries, including the output head. The youngest match wins. fwd_raddr=0 gives fwd_hit=0.

## Timing
- Reset values:
  - Queue empty.
  - in_ready=1, rf_we=0, rf_waddr=0, rf_wdata=0.
  - fwd_hit=0, misalign_err=0, wb_count=0.
- Latency: accept at edge N gives rf_we=1 after edge N, when the queue was empty.
- Throughput: 1 write/cycle with rf_ready held at 1.
- Full: in_ready=0 combinationally from count==DEPTH. There is no same-cycle pass-through; a pop while full raises in_ready the next cycle.
- Simultaneous push and pop: count is unchanged, and the new entry goes to the tail.
- Push into an empty queue while the head pops: allowed; the new entry presents on the next cycle.
- misalign_err is asserted exactly one cycle per faulting accept. Back-to-back faults give consecutive pulses.
- Reset mid-operation: queued entries are discarded with no write issued, and outputs return immediately to reset values.

## Structure
- Package wb_pkg holds:
  - wb_src_e (ALU/MEM/LINK).
  - ld_size_e (BYTE/HALF/WORD/FULL).
  - a wb_entry_t struct {rd, data}, parametrised via localparam widths.
- Sub-module wb_load_format: pure combinational byte select, alignment check and extension. Ports are mem_data, offset, size, unsigned, data_out, misaligned.
- Queue storage, pointers, bypass search and counter live in the top module.

## Test plan
- Byte loads, DATA_W=32: mem_data=32'h12_F4_56_78.
  - off=1 signed → rf_wdata=32'hFFFFFFF4.
  - off=1 unsigned → 32'h000000F4.
  - off=3 signed → 32'h00000078.
- Half and misalign: half, off=2, data 32'hAAAA8001 → 32'hFFFF8001. Half at off=1 → misalign_err pulse, no rf_we, wb_count unchanged.
- Link and ALU: LINK with pc=32'h0000_0040 → rd=31, data 32'h48. ALU result with rd=0 → no rf_we.
- Backpressure, DEPTH=2: rf_ready=0 and 3 pushes → in_ready=0 after 2. Release rf_ready → writes in order, wb_count=2, third push then accepted.
- Bypass: queue holds r5=1 (older) and r5=2 (younger). fwd_raddr=5 → fwd_hit=1, fwd_data=2. fwd_raddr=0 → fwd_hit=0.
- DATA_W=64, full load, off=0: data 64'h0123456789ABCDEF → written unchanged. Word at off=4 with data 64'h...8000_0000 → 64'hFFFFFFFF80000000. Assert rst_b with 2 entries queued → no writes, in_ready=1.
